// File: rtl/fib_index_finder.sv
`default_nettype none
// ============================================================================
//  Module   : fib_index_finder
//  Purpose  : Inverse Fibonacci lookup. Latches a DATA_W-bit value on an
//             accepted start, then walks the series F0, F1, F2 ... one term
//             per clock with its own cur/nxt registers and adder. It reports
//             whether the value is a Fibonacci number and its index n. For a
//             non-member it reports the floor index. Results are held until
//             the next decision.
//  Ports    : clk        - rising-edge clock
//             usr_reset  - asynchronous, active-low reset
//             start      - search request, sampled only while idle
//             value_in   - value to look up, latched on accepted start
//             busy       - high while searching
//             done       - one-cycle pulse when is_fib/index become valid
//             is_fib     - latched value is a Fibonacci number
//             index      - index n (exact, floor, or MAX_IDX on overflow)
//             floor_val  - largest Fibonacci number <= value
//                          (present only with FIB_FLOOR_VAL_EN)
//  Options  : `define FIB_FLOOR_VAL_EN adds floor_val and a prev-term register
//  Revision : 1.0 - initial release
// ============================================================================
module fib_index_finder #(
  parameter int DATA_W  = 16,
  parameter int IDX_W   = 5,
  parameter int MAX_IDX = 24
) (
  input  logic              clk,
  input  logic              usr_reset,
  input  logic              start,
  input  logic [DATA_W-1:0] value_in,
  output logic              busy,
  output logic              done,
  output logic              is_fib,
`ifdef FIB_FLOOR_VAL_EN
  output logic [IDX_W-1:0]  index,
  output logic [DATA_W-1:0] floor_val
`else
  output logic [IDX_W-1:0]  index
`endif
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_SEARCH = 1'b1;

  localparam logic [IDX_W-1:0] c_max_idx = IDX_W'(MAX_IDX);

  logic [0:0]        state_q,  state_d;
  logic              done_q,   done_d;
  logic              is_fib_q, is_fib_d;
  logic [IDX_W-1:0]  index_q,  index_d;
  logic [DATA_W-1:0] target_q, target_d;
  logic [DATA_W-1:0] cur_q,    cur_d;
  logic [DATA_W-1:0] nxt_q,    nxt_d;
  logic [IDX_W-1:0]  idx_q,    idx_d;
`ifdef FIB_FLOOR_VAL_EN
  logic [DATA_W-1:0] prev_q,   prev_d;
  logic [DATA_W-1:0] floor_q,  floor_d;
`endif

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    is_fib_d = is_fib_q;
    index_d  = index_q;
    target_d = target_q;
    cur_d    = cur_q;
    nxt_d    = nxt_q;
    idx_d    = idx_q;
`ifdef FIB_FLOOR_VAL_EN
    prev_d   = prev_q;
    floor_d  = floor_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          target_d = value_in;
          cur_d    = '0;
          nxt_d    = DATA_W'(1);
          idx_d    = '0;
`ifdef FIB_FLOOR_VAL_EN
          prev_d   = '0;
`endif
          state_d  = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (cur_q == target_q) begin
          is_fib_d = 1'b1;
          index_d  = idx_q;
          done_d   = 1'b1;
          state_d  = S_IDLE;
`ifdef FIB_FLOOR_VAL_EN
          floor_d  = cur_q;
`endif
        end else if (cur_q > target_q) begin
          // Overshoot can only happen with idx >= 1 (target 0 matches F0),
          // so idx-1 never wraps.
          is_fib_d = 1'b0;
          index_d  = idx_q - IDX_W'(1);
          done_d   = 1'b1;
          state_d  = S_IDLE;
`ifdef FIB_FLOOR_VAL_EN
          floor_d  = prev_q;
`endif
        end else if (idx_q == c_max_idx) begin
          // Target lies above the largest representable term.
          is_fib_d = 1'b0;
          index_d  = c_max_idx;
          done_d   = 1'b1;
          state_d  = S_IDLE;
`ifdef FIB_FLOOR_VAL_EN
          floor_d  = cur_q;
`endif
        end else begin
          // The wrapped F(MAX_IDX+1) lands in nxt but is never compared.
          cur_d = nxt_q;
          nxt_d = cur_q + nxt_q;
          idx_d = idx_q + IDX_W'(1);
`ifdef FIB_FLOOR_VAL_EN
          prev_d = cur_q;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge usr_reset) begin
    if (!usr_reset) begin
      state_q  <= S_IDLE;
      done_q   <= 1'b0;
      is_fib_q <= 1'b0;
      index_q  <= '0;
      target_q <= '0;
      cur_q    <= '0;
      nxt_q    <= '0;
      idx_q    <= '0;
`ifdef FIB_FLOOR_VAL_EN
      prev_q   <= '0;
      floor_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      is_fib_q <= is_fib_d;
      index_q  <= index_d;
      target_q <= target_d;
      cur_q    <= cur_d;
      nxt_q    <= nxt_d;
      idx_q    <= idx_d;
`ifdef FIB_FLOOR_VAL_EN
      prev_q   <= prev_d;
      floor_q  <= floor_d;
`endif
    end
  end

  assign busy   = (state_q == S_SEARCH);
  assign done   = done_q;
  assign is_fib = is_fib_q;
  assign index  = index_q;
`ifdef FIB_FLOOR_VAL_EN
  assign floor_val = floor_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fib_index_finder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fib_index_finder
//  Purpose  : Self-checking bench for fib_index_finder: a table of directed
//             vectors, random values checked against a series-based reference,
//             and hand-written handshake/reset sequences.
//  Options  : FIB_FLOOR_VAL_EN enables floor_val checking
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fib_index_finder;

  logic        clk = 1'b0;
  logic        usr_reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] value_in = '0;
  logic        busy, done, is_fib;
  logic [4:0]  index;
`ifdef FIB_FLOOR_VAL_EN
  logic [15:0] floor_val;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [15:0] value;
    logic        is_fib;
    int          index;
    int          lat;      // edges after the accepting edge until done
    int          floor_v;
  } vec_t;

  fib_index_finder #(.DATA_W(16), .IDX_W(5), .MAX_IDX(24)) dut (
    .clk       (clk),
    .usr_reset (usr_reset),
    .start     (start),
    .value_in  (value_in),
    .busy      (busy),
    .done      (done),
    .is_fib    (is_fib),
`ifdef FIB_FLOOR_VAL_EN
    .index     (index),
    .floor_val (floor_val)
`else
    .index     (index)
`endif
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: build the series with plain arithmetic and scan it.
  function automatic vec_t model(input int v);
    int   fib [0:24];
    vec_t r;
    fib[0] = 0;
    fib[1] = 1;
    for (int k = 2; k <= 24; k++) fib[k] = fib[k-1] + fib[k-2];
    r.value = 16'(v); r.is_fib = 1'b0; r.index = 24; r.lat = 25; r.floor_v = fib[24];
    for (int k = 0; k <= 24; k++) begin
      if (fib[k] == v) begin
        r.is_fib = 1'b1; r.index = k; r.lat = k + 1; r.floor_v = v;
        return r;
      end
      if (fib[k] > v) begin
        r.index = k - 1; r.lat = k + 1; r.floor_v = fib[k-1];
        return r;
      end
    end
    return r;
  endfunction

  // Drive a start; returns #1 after the accepting edge.
  task automatic launch(input logic [15:0] v);
    @(negedge clk);
    start    = 1'b1;
    value_in = v;
    @(posedge clk);
    #1;
    start    = 1'b0;
    value_in = '0;
  endtask

  // Counts edges until done is seen; returns #1 after the deciding edge.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input vec_t e, input int lat);
    chk({tag, ".lat"},    lat, e.lat);
    chk({tag, ".is_fib"}, is_fib, e.is_fib);
    chk({tag, ".index"},  index, e.index);
    chk({tag, ".busy"},   busy, 0);
`ifdef FIB_FLOOR_VAL_EN
    chk({tag, ".floor"},  floor_val, e.floor_v);
`endif
  endtask

  task automatic run_vec(input string tag, input vec_t e);
    int lat;
    launch(e.value);
    chk({tag, ".busy_on"}, busy, 1);
    wait_done(lat);
    check_result(tag, e, lat);
    @(posedge clk);
    #1;
    chk({tag, ".done_pulse"}, done, 0);
    chk({tag, ".hold_idx"},   index, e.index);
  endtask

  vec_t tbl [10];
  vec_t e;
  int   lat, lat2;

  initial begin
    tbl[0] = '{16'd0,     1'b1, 0,  1,  0};
    tbl[1] = '{16'd13,    1'b1, 7,  8,  13};
    tbl[2] = '{16'd1,     1'b1, 1,  2,  1};
    tbl[3] = '{16'd14,    1'b0, 7,  9,  13};
    tbl[4] = '{16'd46368, 1'b1, 24, 25, 46368};
    tbl[5] = '{16'd65535, 1'b0, 24, 25, 46368};
    tbl[6] = '{16'd4,     1'b0, 4,  6,  3};
    tbl[7] = '{16'd2,     1'b1, 3,  4,  2};
    tbl[8] = '{16'd100,   1'b0, 11, 13, 89};
    tbl[9] = '{16'd46369, 1'b0, 24, 25, 46368};

    // Reset state
    #2;
    chk("rst.busy",   busy, 0);
    chk("rst.done",   done, 0);
    chk("rst.is_fib", is_fib, 0);
    chk("rst.index",  index, 0);
`ifdef FIB_FLOOR_VAL_EN
    chk("rst.floor",  floor_val, 0);
`endif
    repeat (2) @(negedge clk);
    usr_reset = 1'b1;

    // Directed table
    for (int i = 0; i < 10; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

    // Random values against the reference
    for (int i = 0; i < 24; i++) begin
      int v;
      v = (i % 2 == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 300));
      run_vec($sformatf("rnd%0d_v%0d", i, v), model(v));
    end

    // start while busy is ignored
    launch(16'd610);
    repeat (3) @(negedge clk);
    start = 1'b1; value_in = 16'd5;
    @(posedge clk);
    #1;
    start = 1'b0; value_in = '0;
    wait_done(lat);
    check_result("busy_start", model(610), (lat < 0) ? lat : lat + 3);

    // start in the done cycle is accepted
    start = 1'b1; value_in = 16'd5;
    @(posedge clk);
    #1;
    start = 1'b0; value_in = '0;
    chk("done_start.done_drop", done, 0);
    chk("done_start.busy",      busy, 1);
    chk("done_start.hold_fib",  is_fib, 1);
    chk("done_start.hold_idx",  index, 15);
    wait_done(lat2);
    check_result("done_start", model(5), lat2);

    // Reset mid-search aborts with no done
    launch(16'd4181);
    repeat (5) @(posedge clk);
    #2;
    usr_reset = 1'b0;
    #1;
    chk("abort.busy",   busy, 0);
    chk("abort.done",   done, 0);
    chk("abort.is_fib", is_fib, 0);
    chk("abort.index",  index, 0);
`ifdef FIB_FLOOR_VAL_EN
    chk("abort.floor",  floor_val, 0);
`endif
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("abort.no_done", done, 0);
    end
    @(negedge clk);
    usr_reset = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      chk("abort.idle_no_done", done | busy, 0);
    end
    run_vec("after_rst", model(2));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
